// File: rtl/ascon_perm_if.sv
// Command/result bundle between the AEAD control FSM and the Ascon permutation engine.
interface ascon_perm_if #(
  parameter int RATE_W = 64
);
  logic              start_i;
  logic              ready_o;
  logic              load_i;
  logic              rounds_sel_i;
  logic [1:0]        xor_begin_i;
  logic [1:0]        xor_end_i;
  logic [319:0]      state_i;
  logic [127:0]      key_i;
  logic [RATE_W-1:0] data_i;
  logic [319:0]      state_o;
  logic              valid_o;
  logic              busy_o;
  logic [3:0]        round_o;

  modport master (
    output start_i, load_i, rounds_sel_i, xor_begin_i, xor_end_i, state_i, key_i, data_i,
    input  ready_o, state_o, valid_o, busy_o, round_o
  );

  modport slave (
    input  start_i, load_i, rounds_sel_i, xor_begin_i, xor_end_i, state_i, key_i, data_i,
    output ready_o, state_o, valid_o, busy_o, round_o
  );
endinterface

// File: rtl/ascon_perm_engine.sv
// Self-sequencing Ascon permutation: one accepted command runs p^a or p^b, UNROLL rounds
// per clock, with optional data/key XOR before and key/domain-bit XOR after the rounds.
//
//   state   | meaning
//   IDLE    | waiting for a command, state register holds last result
//   RUN     | UNROLL rounds applied per cycle, round index in rnd_q
//   DONE    | result valid for one cycle, a new command may be accepted
module ascon_perm_engine #(
  parameter int UNROLL   = 1,
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter int RATE_W   = 64
) (
  input logic         clock_i,
  input logic         resetb_i,
  ascon_perm_if.slave bus
);

  if ((UNROLL < 1) || ((ROUNDS_A % UNROLL) != 0) || ((ROUNDS_B % UNROLL) != 0)) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must divide ROUNDS_A and ROUNDS_B");
  end
  if ((ROUNDS_A < 1) || (ROUNDS_A > 12) || (ROUNDS_B < 1) || (ROUNDS_B > 12)) begin : g_bad_rounds
    $error("ascon_perm_engine: round counts must lie in 1..12");
  end
  if ((RATE_W != 64) && (RATE_W != 128)) begin : g_bad_rate
    $error("ascon_perm_engine: RATE_W must be 64 or 128");
  end

  localparam logic [3:0] R0_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] R0_B = 4'(12 - ROUNDS_B);
  localparam logic [4:0] STEP = 5'(UNROLL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [319:0]      state_q, state_d;
  logic [3:0]        rnd_q, rnd_d;
  logic              first_q, first_d;
  logic              load_q, load_d;
  logic [1:0]        xb_q, xb_d;
  logic [1:0]        xe_q, xe_d;
  logic [127:0]      key_q, key_d;
  logic [RATE_W-1:0] data_q, data_d;

  logic [319:0]      perm_out;
  logic [4:0]        rnd_next;
  logic              last_rnd;
  logic              accept;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    x2[7:0] = x2[7:0] ^ {~r, r};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = x0 ^ (~x1 & x2);
    t1 = x1 ^ (~x2 & x3);
    t2 = x2 ^ (~x3 & x4);
    t3 = x3 ^ (~x4 & x0);
    t4 = x4 ^ (~x0 & x1);
    t1 = t1 ^ t0;
    t3 = t3 ^ t2;
    t0 = t0 ^ t4;
    t2 = ~t2;
    x0 = t0 ^ ror64(t0, 19) ^ ror64(t0, 28);
    x1 = t1 ^ ror64(t1, 61) ^ ror64(t1, 39);
    x2 = t2 ^ ror64(t2, 1)  ^ ror64(t2, 6);
    x3 = t3 ^ ror64(t3, 10) ^ ror64(t3, 17);
    x4 = t4 ^ ror64(t4, 7)  ^ ror64(t4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  assign rnd_next = {1'b0, rnd_q} + STEP;
  assign last_rnd = (rnd_next == 5'd12);

  // External state is only looked at in the first RUN cycle; later cycles loop on state_q.
  always_comb begin
    logic [319:0] cur;
    cur = state_q;
    if (first_q) begin
      if (load_q) begin
        cur = bus.state_i;
      end
      case (xb_q)
        2'b01:   cur[319 -: RATE_W] = cur[319 -: RATE_W] ^ data_q;
        2'b10:   cur[255:128] = cur[255:128] ^ key_q;
        2'b11:   cur[0] = ~cur[0];
        default: ;
      endcase
    end
    for (int k = 0; k < UNROLL; k++) begin
      cur = ascon_round(cur, rnd_q + 4'(k));
    end
    if (last_rnd) begin
      if (xe_q[0]) cur[127:0] = cur[127:0] ^ key_q;
      if (xe_q[1]) cur[0] = ~cur[0];
    end
    perm_out = cur;
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    first_d = first_q;
    load_d  = load_q;
    xb_d    = xb_q;
    xe_d    = xe_q;
    key_d   = key_q;
    data_d  = data_q;
    accept  = 1'b0;
    case (fsm_q)
      ST_IDLE, ST_DONE: begin
        accept = bus.start_i;
        fsm_d  = accept ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        state_d = perm_out;
        rnd_d   = rnd_next[3:0];
        first_d = 1'b0;
        if (last_rnd) begin
          fsm_d = ST_DONE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
    if (accept) begin
      first_d = 1'b1;
      rnd_d   = bus.rounds_sel_i ? R0_B : R0_A;
      load_d  = bus.load_i;
      xb_d    = bus.xor_begin_i;
      xe_d    = bus.xor_end_i;
      key_d   = bus.key_i;
      data_d  = bus.data_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      first_q <= 1'b0;
      load_q  <= 1'b0;
      xb_q    <= '0;
      xe_q    <= '0;
      key_q   <= '0;
      data_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      first_q <= first_d;
      load_q  <= load_d;
      xb_q    <= xb_d;
      xe_q    <= xe_d;
      key_q   <= key_d;
      data_q  <= data_d;
    end
  end

  assign bus.ready_o = (fsm_q == ST_IDLE) || (fsm_q == ST_DONE);
  assign bus.busy_o  = (fsm_q == ST_RUN);
  assign bus.valid_o = (fsm_q == ST_DONE);
  assign bus.round_o = (fsm_q == ST_RUN) ? rnd_q : 4'd0;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Directed bench: four engine builds (UNROLL 1/2/3, and RATE_W=128 with ROUNDS_B=8) driven in lockstep.
module tb_ascon_perm_engine;

  localparam logic [63:0]  IV    = 64'h80400C0600000000;
  localparam logic [127:0] KEY   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NONCE = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] TAG   = 128'hE355159F292911F794CB1432A0103A8A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         load  = 1'b0;
  logic         sel   = 1'b0;
  logic [1:0]   xb    = 2'b00;
  logic [1:0]   xe    = 2'b00;
  logic [127:0] key   = '0;
  logic [127:0] data  = '0;
  logic [319:0] st_in [4];

  ascon_perm_if #(.RATE_W(64))  if1 ();
  ascon_perm_if #(.RATE_W(64))  if2 ();
  ascon_perm_if #(.RATE_W(64))  if3 ();
  ascon_perm_if #(.RATE_W(128)) if4 ();

  ascon_perm_engine #(.UNROLL(1)) u1 (.clock_i(clk), .resetb_i(rst), .bus(if1.slave));
  ascon_perm_engine #(.UNROLL(2)) u2 (.clock_i(clk), .resetb_i(rst), .bus(if2.slave));
  ascon_perm_engine #(.UNROLL(3)) u3 (.clock_i(clk), .resetb_i(rst), .bus(if3.slave));
  ascon_perm_engine #(.UNROLL(2), .ROUNDS_B(8), .RATE_W(128)) u4 (.clock_i(clk), .resetb_i(rst), .bus(if4.slave));

  assign {if1.start_i, if2.start_i, if3.start_i, if4.start_i} = {4{start}};
  assign {if1.load_i, if2.load_i, if3.load_i, if4.load_i} = {4{load}};
  assign {if1.rounds_sel_i, if2.rounds_sel_i, if3.rounds_sel_i, if4.rounds_sel_i} = {4{sel}};
  assign {if1.xor_begin_i, if2.xor_begin_i, if3.xor_begin_i, if4.xor_begin_i} = {4{xb}};
  assign {if1.xor_end_i, if2.xor_end_i, if3.xor_end_i, if4.xor_end_i} = {4{xe}};
  assign {if1.key_i, if2.key_i, if3.key_i, if4.key_i} = {4{key}};
  assign if1.data_i = data[127:64];
  assign if2.data_i = data[127:64];
  assign if3.data_i = data[127:64];
  assign if4.data_i = data;
  assign if1.state_i = st_in[0];
  assign if2.state_i = st_in[1];
  assign if3.state_i = st_in[2];
  assign if4.state_i = st_in[3];

  logic [319:0] st_o [4];
  logic         vld  [4];
  logic         rdy  [4];
  logic         bsy  [4];
  logic [3:0]   rnd  [4];
  assign st_o[0] = if1.state_o; assign vld[0] = if1.valid_o; assign rdy[0] = if1.ready_o;
  assign st_o[1] = if2.state_o; assign vld[1] = if2.valid_o; assign rdy[1] = if2.ready_o;
  assign st_o[2] = if3.state_o; assign vld[2] = if3.valid_o; assign rdy[2] = if3.ready_o;
  assign st_o[3] = if4.state_o; assign vld[3] = if4.valid_o; assign rdy[3] = if4.ready_o;
  assign bsy[0] = if1.busy_o; assign rnd[0] = if1.round_o;
  assign bsy[1] = if2.busy_o; assign rnd[1] = if2.round_o;
  assign bsy[2] = if3.busy_o; assign rnd[2] = if3.round_o;
  assign bsy[3] = if4.busy_o; assign rnd[3] = if4.round_o;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           vcnt [4] = '{0, 0, 0, 0};
  int           vcyc [4] = '{0, 0, 0, 0};
  logic [319:0] res  [4];
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i] === 1'b1) begin
        vcnt[i] = vcnt[i] + 1;
        vcyc[i] = cyc;
        res[i]  = st_o[i];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int idx, input logic [319:0] obs, input logic [319:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s u%0d: observed %0h expected %0h", tag, idx + 1, obs, expv);
    end
  endtask

  int         lat    [4];
  logic [3:0] rfirst [4];

  // One command issued to all builds; scr[0] flips data and scr[1] flips key/state_i once the command is latched.
  task automatic cmd(input logic ld, input logic sl, input logic [1:0] xbv, input logic [1:0] xev,
                     input logic [1:0] scr);
    int base [4];
    int t0;
    int guard;
    for (int i = 0; i < 4; i++) base[i] = vcnt[i];
    load  = ld;
    sel   = sl;
    xb    = xbv;
    xe    = xev;
    start = 1'b1;
    t0    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) rfirst[i] = rnd[i];
    if (scr[0]) data = ~data;
    if (scr[1]) key = ~key;
    @(posedge clk); #1;
    if (scr[1]) for (int i = 0; i < 4; i++) st_in[i] = ~st_in[i];
    guard = 0;
    while (((vcnt[0] == base[0]) || (vcnt[1] == base[1]) || (vcnt[2] == base[2]) ||
            (vcnt[3] == base[3])) && (guard < 40)) begin
      @(posedge clk); #1;
      guard++;
    end
    for (int i = 0; i < 4; i++) begin
      chk("valid pulses per command", i, 320'(vcnt[i] - base[i]), 320'd1);
      lat[i] = vcyc[i] - t0;
    end
  endtask

  int           lat_a   [4] = '{13, 7, 5, 7};
  int           lat_b   [4] = '{7, 4, 3, 5};
  int           r0_b    [4] = '{6, 6, 6, 4};
  int           mid_rnd [4] = '{2, 4, 6, 4};
  int           b2b     [4] = '{3, 5, 7, 4};
  int           base2   [4];
  logic [319:0] s0      [4];
  logic [319:0] ra      [4];

  initial begin
    for (int i = 0; i < 4; i++) st_in[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("reset ready", i, 320'(rdy[i]), 320'd1);
      chk("reset busy", i, 320'(bsy[i]), 320'd0);
      chk("reset valid", i, 320'(vld[i]), 320'd0);
      chk("reset round", i, 320'(rnd[i]), 320'd0);
      chk("reset state", i, st_o[i], 320'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // p^a started, then reset while every build is still in RUN
    for (int i = 0; i < 4; i++) st_in[i] = {IV, KEY, NONCE};
    key = KEY;
    load = 1'b1; sel = 1'b0; xb = 2'b00; xe = 2'b01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) chk("first round index p^a", i, 320'(rnd[i]), 320'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("mid-run round index", i, 320'(rnd[i]), 320'(mid_rnd[i]));
      chk("mid-run busy", i, 320'(bsy[i]), 320'd1);
      chk("mid-run ready", i, 320'(rdy[i]), 320'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort state cleared", i, st_o[i], 320'd0);
      chk("abort ready", i, 320'(rdy[i]), 320'd1);
    end
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("abort no valid", i, 320'(vcnt[i]), 320'd0);

    // Ascon-128, empty AD and PT: init with K and domain bit folded into xor_end
    cmd(1'b1, 1'b0, 2'b00, 2'b11, 2'b00);
    for (int i = 0; i < 4; i++) chk("init latency", i, 320'(lat[i]), 320'(lat_a[i]));

    // Finalisation on the padded state: x0 ^= 0x80.., K into x1||x2, p^a, K into x3||x4
    for (int i = 0; i < 4; i++) st_in[i] = res[i] ^ {64'h8000000000000000, 256'd0};
    cmd(1'b1, 1'b0, 2'b10, 2'b01, 2'b00);
    for (int i = 0; i < 4; i++) begin
      chk("final latency", i, 320'(lat[i]), 320'(lat_a[i]));
      chk("tag x3||x4", i, {192'd0, res[i][127:0]}, {192'd0, TAG});
      s0[i] = res[i];
    end

    // Loop p^b with all-ones rate data; data changes right after acceptance
    data = '1;
    cmd(1'b0, 1'b1, 2'b01, 2'b01, 2'b01);
    for (int i = 0; i < 4; i++) begin
      chk("p^b latency", i, 320'(lat[i]), 320'(lat_b[i]));
      chk("p^b first round index", i, 320'(rfirst[i]), 320'(r0_b[i]));
      ra[i] = res[i];
    end

    // Same p^b with the rate inversion done by the bench; key and state_i change during RUN
    data = '1;
    key  = KEY;
    for (int i = 0; i < 3; i++) st_in[i] = s0[i] ^ {64'hFFFFFFFFFFFFFFFF, 256'd0};
    st_in[3] = s0[3] ^ {128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 192'd0};
    cmd(1'b1, 1'b1, 2'b00, 2'b01, 2'b10);
    for (int i = 0; i < 4; i++) chk("rate xor equivalence", i, res[i], ra[i]);

    // start held high for 20 cycles: only DONE/IDLE cycles accept
    key = KEY;
    for (int i = 0; i < 4; i++) base2[i] = vcnt[i];
    load = 1'b0; sel = 1'b1; xb = 2'b00; xe = 2'b00; start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("back-to-back valid count", i, 320'(vcnt[i] - base2[i]), 320'(b2b[i]));
      chk("idle after burst", i, 320'(rdy[i]), 320'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
